// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache controller's request path.
// The word packer imports the FSM state enum and the width helpers from here.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_NBYTES = 4;

  // Byte counts run 0..nbytes inclusive, so one bit more than log2.
  function automatic int wb_width(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

  localparam int DEF_WB_W = wb_width(DEF_NBYTES);

endpackage

// File: rtl/queue_word_packer.sv
// Pops bytes from the request queue and packs them little-endian into words
// for the cache request decoder; a flush emits a partially filled word.
module queue_word_packer
  import cache_ctrl_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NBYTES = DEF_NBYTES,
  localparam int WB_W  = wb_width(NBYTES),
  localparam int WORD_W = BYTE_W * NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_empty,
  input  logic [BYTE_W-1:0] q_data,
  output logic              q_read_en,
  input  logic              flush,
  output logic [WORD_W-1:0] word_data,
  output logic [WB_W-1:0]   word_bytes,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshakes: the queue pops on a cycle with q_read_en high and returns the
  // byte on q_data one cycle later; a word transfers on any rising clk edge
  // where word_valid && word_ready, and word_data/word_bytes hold until then.

  state_t          state;
  logic [WB_W-1:0] byte_cnt;
  logic            flush_pending;

  assign flush_pending = flush && (byte_cnt != '0);

  // A flush with pending bytes blocks the pop so the queued byte starts the next word.
  assign q_read_en = !rst && (state == FETCH) && !q_empty && !flush_pending;
  assign busy      = (byte_cnt != '0) || word_valid;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      byte_cnt   <= '0;
      word_data  <= '0;
      word_bytes <= '0;
      word_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (flush_pending) begin
            state      <= HOLD;
            word_bytes <= byte_cnt;
            word_valid <= 1'b1;
          end else if (!q_empty) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt == WB_W'(i)) word_data[i*BYTE_W +: BYTE_W] <= q_data;
          end
          byte_cnt <= byte_cnt + WB_W'(1);
          if (byte_cnt == WB_W'(NBYTES - 1)) begin
            state      <= HOLD;
            word_bytes <= WB_W'(NBYTES);
            word_valid <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        HOLD: begin
          if (word_ready) begin
            state      <= FETCH;
            byte_cnt   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  pop_on_empty: assert property (@(posedge clk) disable iff (rst) !(q_read_en && q_empty));

endmodule

// File: tb/tb_queue_word_packer.sv
// Bench for queue_word_packer: a behavioural byte queue feeds the DUT, and a
// scoreboard of expected words is checked at every accepted handshake.
module tb_queue_word_packer;
  import cache_ctrl_pkg::*;

  localparam int BW = 8;
  localparam int NB = 4;
  localparam int WW = BW * NB;
  localparam int CW = wb_width(NB);
  localparam int EW = CW + WW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          q_empty = 1'b1;
  logic [BW-1:0] q_data = '0;
  logic          q_read_en;
  logic          flush = 1'b0;
  logic [WW-1:0] word_data;
  logic [CW-1:0] word_bytes;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          busy;
  state_t        dbg_state;

  always #5 clk = ~clk;

  queue_word_packer #(.BYTE_W(BW), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_read_en(q_read_en),
    .flush(flush), .word_data(word_data), .word_bytes(word_bytes),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- queue model and scoreboard ----------------
  logic [BW-1:0] fifo[$];
  logic [EW-1:0] exp_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_data;
  logic [CW-1:0] prev_bytes;
  logic          last_re, last_wv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [BW-1:0] b);
    fifo.push_back(b);
    q_empty = 1'b0;
  endtask

  function automatic logic [EW-1:0] pack(input int nbytes, input logic [WW-1:0] w);
    return {CW'(nbytes), w};
  endfunction

  // One clock cycle; entered and left at the falling edge with inputs applied.
  task automatic step();
    #1;
    last_re = q_read_en;
    last_wv = word_valid;
    if (!rst) begin
      check("pop_empty", {63'd0, q_read_en && q_empty}, 64'd0);
      if (prev_hold) begin
        check("hold_valid", {63'd0, word_valid}, 64'd1);
        check("hold_data", {32'd0, word_data}, {32'd0, prev_data});
        check("hold_bytes", {61'd0, word_bytes}, {61'd0, prev_bytes});
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {29'd0, word_bytes, word_data}, 64'd0);
        end else begin
          check("word", {29'd0, word_bytes, word_data}, {29'd0, exp_q.pop_front()});
        end
      end
      prev_hold  = word_valid && !word_ready;
      prev_data  = word_data;
      prev_bytes = word_bytes;
    end else begin
      check("rst_read_en", {63'd0, q_read_en}, 64'd0);
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst) fifo.delete();
    else if (last_re && fifo.size() > 0) q_data = fifo.pop_front();
    q_empty = (fifo.size() == 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() > 0; i++) step();
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {63'd0, word_valid}, 64'd0);
    check({tag, "_data"}, {32'd0, word_data}, 64'd0);
    check({tag, "_bytes"}, {61'd0, word_bytes}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, FETCH});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            n;
    logic [BW-1:0] b[NB];
    logic          do_flush;
    logic [WW-1:0] exp_word;
    int            exp_bytes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            pop_mask, wv_mask;
    logic [BW-1:0] pend[$];
    logic [WW-1:0] w;

    vecs[0] = '{4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 32'h44332211, 4};
    vecs[1] = '{2, '{8'h5A, 8'h6B, 8'h00, 8'h00}, 1'b1, 32'h00006B5A, 2};
    vecs[2] = '{1, '{8'h01, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h00000001, 1};
    vecs[3] = '{3, '{8'hC1, 8'hC2, 8'hC3, 8'h00}, 1'b1, 32'h00C3C2C1, 3};
    vecs[4] = '{4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0, 32'hEFBEADDE, 4};
    vecs[5] = '{4, '{8'hFF, 8'h00, 8'hFF, 8'h00}, 1'b0, 32'h00FF00FF, 4};

    do_reset();
    check_idle("reset");
    check("reset_read_en", {63'd0, q_read_en}, 64'd0);

    // Table: pack or flush from an idle packer.
    foreach (vecs[v]) begin
      do_reset();
      word_ready = 1'b1;
      for (int j = 0; j < vecs[v].n; j++) push(vecs[v].b[j]);
      exp_q.push_back(pack(vecs[v].exp_bytes, vecs[v].exp_word));
      if (vecs[v].do_flush) begin
        for (int i = 0; i < 10; i++) step();
        check("vec_no_early_word", 64'(exp_q.size()), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_drain(4);
      end else begin
        wait_drain(20);
      end
      step();
      check("vec_idle_busy", {63'd0, busy}, 64'd0);
    end

    // Throughput: pops on cycles 0,2,4,6, word_valid only on cycle 8.
    do_reset();
    word_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    exp_q.push_back(pack(4, 32'h44332211));
    pop_mask = 0;
    wv_mask  = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (last_re) pop_mask |= (1 << c);
      if (last_wv) wv_mask |= (1 << c);
    end
    check("tp_pop_cycles", 64'(pop_mask), 64'h055);
    check("tp_valid_cycles", 64'(wv_mask), 64'h100);
    check("tp_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: word held stable, no pops while held.
    do_reset();
    word_ready = 1'b0;
    for (int j = 1; j <= 8; j++) push(8'(j));
    exp_q.push_back(pack(4, 32'h04030201));
    exp_q.push_back(pack(4, 32'h08070605));
    for (int i = 0; i < 12 && !word_valid; i++) step();
    check("bp_valid", {63'd0, word_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_no_pop", {63'd0, last_re}, 64'd0);
    end
    check("bp_data", {32'd0, word_data}, 64'h04030201);
    word_ready = 1'b1;
    wait_drain(30);

    // Empty stall between bytes of one word.
    do_reset();
    word_ready = 1'b1;
    push(8'hAA);
    exp_q.push_back(pack(4, 32'hDDCCBBAA));
    for (int i = 0; i < 10; i++) step();
    check("stall_busy", {63'd0, busy}, 64'd1);
    push(8'hBB); push(8'hCC); push(8'hDD);
    wait_drain(20);

    // Flush with nothing pending has no effect.
    do_reset();
    word_ready = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("flush0_valid", {63'd0, last_wv}, 64'd0);
    end
    check("flush0_busy", {63'd0, busy}, 64'd0);
    flush = 1'b0;

    // Flush beats a simultaneous pop; the queued byte leads the next word.
    do_reset();
    word_ready = 1'b1;
    push(8'h10);
    for (int i = 0; i < 4; i++) step();
    exp_q.push_back(pack(1, 32'h00000010));
    exp_q.push_back(pack(4, 32'h50403020));
    push(8'h20);
    flush = 1'b1;
    step();
    check("fvp_no_pop", {63'd0, last_re}, 64'd0);
    flush = 1'b0;
    push(8'h30); push(8'h40); push(8'h50);
    wait_drain(30);

    // Reset mid-word discards captured bytes.
    do_reset();
    word_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 7; i++) step();
    check("rmw_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    push(8'h99);
    step();
    rst = 1'b0;
    check_idle("rmw");
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    exp_q.push_back(pack(4, 32'hA4A3A2A1));
    wait_drain(20);

    // Random traffic: every byte pushed comes out in order, four per word.
    do_reset();
    pend.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [BW-1:0] b;
        b = BW'($urandom);
        push(b);
        pend.push_back(b);
      end
      if (pend.size() == NB) begin
        w = '0;
        for (int k = 0; k < NB; k++) w += WW'(pend[k]) << (BW * k);
        exp_q.push_back(pack(NB, w));
        pend.delete();
      end
      word_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    while (pend.size() != 0 && pend.size() < NB) begin
      logic [BW-1:0] b;
      b = BW'($urandom);
      push(b);
      pend.push_back(b);
    end
    if (pend.size() == NB) begin
      w = '0;
      for (int k = 0; k < NB; k++) w += WW'(pend[k]) << (BW * k);
      exp_q.push_back(pack(NB, w));
    end
    word_ready = 1'b1;
    wait_drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
    $fatal(1);
  end

endmodule
